// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared state encoding and default screen/ball/paddle geometry
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } pong_state_t;

  localparam int unsigned C_H_RES          = 640;
  localparam int unsigned C_V_RES          = 480;
  localparam int unsigned C_BALL_SIZE      = 8;
  localparam int unsigned C_SPEED          = 2;
  localparam int unsigned C_PADDLE_W       = 8;
  localparam int unsigned C_PADDLE_H       = 64;
  localparam int unsigned C_LEFT_PADDLE_X  = 16;
  localparam int unsigned C_RIGHT_PADDLE_X = 616;
  localparam int unsigned C_SERVE_FRAMES   = 60;
  localparam int unsigned C_WIN_SCORE      = 7;

  // Top-left coordinate that places a ball of edge `size` centred on `res`.
  function automatic logic [9:0] centre_of(input int unsigned res, input int unsigned size);
    return 10'((res - size) / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_play_ctrl_if.sv
// ============================================================================
// pong_play_ctrl_if : frame/paddle inputs and ball/score outputs of the
//                     play controller, with driver and controller modports
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

interface pong_play_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic [9:0] paddle_ly;
  logic [9:0] paddle_ry;
  logic [9:0] ballx;
  logic [9:0] bally;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_scored;
  logic       game_over;

  modport master (
    output frame_tick, start, paddle_ly, paddle_ry,
    input  ballx, bally, score_l, score_r, point_scored, game_over
  );

  modport slave (
    input  frame_tick, start, paddle_ly, paddle_ry,
    output ballx, bally, score_l, score_r, point_scored, game_over
  );
endinterface

`default_nettype wire

// File: rtl/pong_play_ctrl_ball_step.sv
// ============================================================================
// ball_step : combinational single-frame ball motion with wall and paddle
//             reflection and left/right miss detection
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module ball_step
  import pong_pkg::*;
#(
  parameter int unsigned H_RES          = C_H_RES,
  parameter int unsigned V_RES          = C_V_RES,
  parameter int unsigned BALL_SIZE      = C_BALL_SIZE,
  parameter int unsigned SPEED          = C_SPEED,
  parameter int unsigned PADDLE_W       = C_PADDLE_W,
  parameter int unsigned PADDLE_H       = C_PADDLE_H,
  parameter int unsigned LEFT_PADDLE_X  = C_LEFT_PADDLE_X,
  parameter int unsigned RIGHT_PADDLE_X = C_RIGHT_PADDLE_X
) (
  input  logic [9:0] ballx,
  input  logic [9:0] bally,
  input  logic       dir_x,
  input  logic       dir_y,
  input  logic [9:0] paddle_ly,
  input  logic [9:0] paddle_ry,
  output logic [9:0] next_ballx,
  output logic [9:0] next_bally,
  output logic       next_dir_x,
  output logic       next_dir_y,
  output logic       miss_l,
  output logic       miss_r
);

  // 11-bit working width keeps every sum and compare free of wrap-around.
  localparam logic [10:0] C_SPD   = 11'(SPEED);
  localparam logic [10:0] C_BALL  = 11'(BALL_SIZE);
  localparam logic [10:0] C_PH    = 11'(PADDLE_H);
  localparam logic [10:0] C_HMAX  = 11'(H_RES);
  localparam logic [10:0] C_YMAX  = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] C_LF    = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] C_RF    = 11'(RIGHT_PADDLE_X - BALL_SIZE);

  logic [10:0] bx;
  logic [10:0] by;
  logic        overlap_l;
  logic        overlap_r;

  assign bx = {1'b0, ballx};
  assign by = {1'b0, bally};

  assign overlap_l = (by + C_BALL > {1'b0, paddle_ly}) && (by < {1'b0, paddle_ly} + C_PH);
  assign overlap_r = (by + C_BALL > {1'b0, paddle_ry}) && (by < {1'b0, paddle_ry} + C_PH);

  always_comb begin
    next_ballx = ballx;
    next_bally = bally;
    next_dir_x = dir_x;
    next_dir_y = dir_y;
    miss_l     = 1'b0;
    miss_r     = 1'b0;

    if (dir_y) begin
      if (by + C_SPD >= C_YMAX) begin
        next_bally = 10'(C_YMAX);
        next_dir_y = 1'b0;
      end else begin
        next_bally = 10'(by + C_SPD);
      end
    end else begin
      if (by <= C_SPD) begin
        next_bally = 10'd0;
        next_dir_y = 1'b1;
      end else begin
        next_bally = 10'(by - C_SPD);
      end
    end

    if (!dir_x) begin
      if (bx >= C_LF && bx <= C_LF + C_SPD && overlap_l) begin
        next_ballx = 10'(C_LF);
        next_dir_x = 1'b1;
      end else if (bx < C_SPD) begin
        miss_l = 1'b1;
      end else begin
        next_ballx = 10'(bx - C_SPD);
      end
    end else begin
      // RF-SPEED <= bx is written as bx+SPEED >= RF so a small RF cannot underflow.
      if (bx + C_SPD >= C_RF && bx <= C_RF && overlap_r) begin
        next_ballx = 10'(C_RF);
        next_dir_x = 1'b0;
      end else if (bx + C_BALL + C_SPD > C_HMAX) begin
        miss_r = 1'b1;
      end else begin
        next_ballx = 10'(bx + C_SPD);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pong_play_ctrl.sv
// ============================================================================
// pong_play_ctrl : game sequencer (idle, serve delay, play, point, game over)
//                  holding ball position, directions and both scores
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module pong_play_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned H_RES          = C_H_RES,
  parameter int unsigned V_RES          = C_V_RES,
  parameter int unsigned BALL_SIZE      = C_BALL_SIZE,
  parameter int unsigned SPEED          = C_SPEED,
  parameter int unsigned PADDLE_W       = C_PADDLE_W,
  parameter int unsigned PADDLE_H       = C_PADDLE_H,
  parameter int unsigned LEFT_PADDLE_X  = C_LEFT_PADDLE_X,
  parameter int unsigned RIGHT_PADDLE_X = C_RIGHT_PADDLE_X,
  parameter int unsigned SERVE_FRAMES   = C_SERVE_FRAMES,
  parameter int unsigned WIN_SCORE      = C_WIN_SCORE
) (
  input  logic            clk,
  input  logic            rst,
  pong_play_ctrl_if.slave bus
);

  localparam int unsigned CNT_W   = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] C_SERVE = CNT_W'(SERVE_FRAMES);
  localparam logic [3:0]       C_WIN   = 4'(WIN_SCORE);
  localparam logic [9:0]       C_CX    = centre_of(H_RES, BALL_SIZE);
  localparam logic [9:0]       C_CY    = centre_of(V_RES, BALL_SIZE);

  pong_state_t      state_q, state_d;
  logic [9:0]       ballx_q, ballx_d;
  logic [9:0]       bally_q, bally_d;
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             point_q, point_d;
  logic             game_over_q, game_over_d;
  logic             scorer_l_q, scorer_l_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;

  logic [9:0] step_x, step_y;
  logic       step_dx, step_dy;
  logic       miss_l, miss_r;
  logic       win;

  ball_step #(
    .H_RES          (H_RES),
    .V_RES          (V_RES),
    .BALL_SIZE      (BALL_SIZE),
    .SPEED          (SPEED),
    .PADDLE_W       (PADDLE_W),
    .PADDLE_H       (PADDLE_H),
    .LEFT_PADDLE_X  (LEFT_PADDLE_X),
    .RIGHT_PADDLE_X (RIGHT_PADDLE_X)
  ) u_ball_step (
    .ballx      (ballx_q),
    .bally      (bally_q),
    .dir_x      (dir_x_q),
    .dir_y      (dir_y_q),
    .paddle_ly  (bus.paddle_ly),
    .paddle_ry  (bus.paddle_ry),
    .next_ballx (step_x),
    .next_bally (step_y),
    .next_dir_x (step_dx),
    .next_dir_y (step_dy),
    .miss_l     (miss_l),
    .miss_r     (miss_r)
  );

  assign win = scorer_l_q ? (score_l_q == C_WIN) : (score_r_q == C_WIN);

  always_comb begin
    state_d     = state_q;
    ballx_d     = ballx_q;
    bally_d     = bally_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_d     = 1'b0;
    game_over_d = game_over_q;
    scorer_l_d  = scorer_l_q;
    serve_cnt_d = serve_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_cnt_d = '0;
          game_over_d = 1'b0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          serve_cnt_d = serve_cnt_q + CNT_W'(1);
          if (serve_cnt_d == C_SERVE) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          // Score, recentre and serve direction all land on entry to POINT.
          if (miss_l || miss_r) begin
            scorer_l_d  = miss_r;
            if (miss_r) score_l_d = score_l_q + 4'd1;
            else        score_r_d = score_r_q + 4'd1;
            point_d     = 1'b1;
            ballx_d     = C_CX;
            bally_d     = C_CY;
            dir_x_d     = miss_r;
            serve_cnt_d = '0;
            state_d     = ST_POINT;
          end else begin
            ballx_d = step_x;
            bally_d = step_y;
            dir_x_d = step_dx;
            dir_y_d = step_dy;
          end
        end
      end
      ST_POINT: begin
        game_over_d = win;
        state_d     = win ? ST_GAME_OVER : ST_SERVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ballx_q     <= C_CX;
      bally_q     <= C_CY;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
      scorer_l_q  <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ballx_q     <= ballx_d;
      bally_q     <= bally_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_q     <= point_d;
      game_over_q <= game_over_d;
      scorer_l_q  <= scorer_l_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign bus.ballx        = ballx_q;
  assign bus.bally        = bally_q;
  assign bus.score_l      = score_l_q;
  assign bus.score_r      = score_r_q;
  assign bus.point_scored = point_q;
  assign bus.game_over    = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_play_ctrl.sv
// ============================================================================
// tb_pong_play_ctrl : randomized game play against a behavioural game model,
//                     expected outputs queued and compared by a monitor
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_pong_play_ctrl;

  localparam int H = 640, V = 480, B = 8, S = 2, PW = 8, PH = 64;
  localparam int LPX = 16, RPX = 616, SF = 60, WIN = 7;
  localparam int CX = 316, CY = 236, LF = 24, RF = 608;
  localparam int N_CYCLES = 40000;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_play_ctrl_if bus();

  pong_play_ctrl #(
    .H_RES(H), .V_RES(V), .BALL_SIZE(B), .SPEED(S), .PADDLE_W(PW), .PADDLE_H(PH),
    .LEFT_PADDLE_X(LPX), .RIGHT_PADDLE_X(RPX), .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int bx; int by; int sl; int sr; int pt; int go;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_points = 0;
  int n_games  = 0;

  // Game model state
  int m_st, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_cnt, m_pt, m_left_scored;

  task automatic model_reset();
    m_st = M_IDLE; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_pt = 0; m_left_scored = 0;
  endtask

  function automatic bit touches(input int by, input int py);
    return (by + B > py) && (by < py + PH);
  endfunction

  task automatic model_step(input bit start, input bit tick, input int ly, input int ry);
    int nx, ny, ndx, ndy;
    bit miss, left_scores;
    m_pt = 0;
    case (m_st)
      M_IDLE, M_OVER: if (start) begin
        m_sl = 0; m_sr = 0; m_cnt = 0; m_st = M_SERVE;
      end
      M_SERVE: if (tick) begin
        m_cnt++;
        if (m_cnt == SF) m_st = M_PLAY;
      end
      M_PLAY: if (tick) begin
        nx = m_bx; ny = m_by; ndx = m_dx; ndy = m_dy; miss = 0; left_scores = 0;
        if (m_dy == 1) begin
          if (m_by + S >= V - B) begin ny = V - B; ndy = 0; end
          else ny = m_by + S;
        end else begin
          if (m_by <= S) begin ny = 0; ndy = 1; end
          else ny = m_by - S;
        end
        if (m_dx == 0) begin
          if (m_bx >= LF && m_bx <= LF + S && touches(m_by, ly)) begin nx = LF; ndx = 1; end
          else if (m_bx < S) begin miss = 1; left_scores = 0; end
          else nx = m_bx - S;
        end else begin
          if (m_bx >= RF - S && m_bx <= RF && touches(m_by, ry)) begin nx = RF; ndx = 0; end
          else if (m_bx + B + S > H) begin miss = 1; left_scores = 1; end
          else nx = m_bx + S;
        end
        if (miss) begin
          if (left_scores) m_sl++; else m_sr++;
          m_pt = 1; m_bx = CX; m_by = CY; m_dx = left_scores ? 1 : 0;
          m_cnt = 0; m_left_scored = left_scores; m_st = M_POINT;
          n_points++;
        end else begin
          m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
        end
      end
      M_POINT: begin
        if ((m_left_scored ? m_sl : m_sr) == WIN) begin m_st = M_OVER; n_games++; end
        else m_st = M_SERVE;
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.bx = m_bx; e.by = m_by; e.sl = m_sl; e.sr = m_sr; e.pt = m_pt;
    e.go = (m_st == M_OVER) ? 1 : 0;
    return e;
  endfunction

  task automatic check_now(input string name, input exp_t e);
    n_checks++;
    if (int'(bus.ballx) == e.bx && int'(bus.bally) == e.by &&
        int'(bus.score_l) == e.sl && int'(bus.score_r) == e.sr &&
        int'(bus.point_scored) == e.pt && int'(bus.game_over) == e.go) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got (x=%0d y=%0d sl=%0d sr=%0d pt=%0d go=%0d) exp (x=%0d y=%0d sl=%0d sr=%0d pt=%0d go=%0d)",
               name, $time, bus.ballx, bus.bally, bus.score_l, bus.score_r,
               bus.point_scored, bus.game_over, e.bx, e.by, e.sl, e.sr, e.pt, e.go);
    end
  endtask

  // Monitor: outputs are registered every cycle, so each cycle presents one result.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check_now("out_cmp", e);
    end
  end

  function automatic int clamp_paddle(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  initial begin
    exp_t e;
    bit did_mid_reset;
    bit st, tk;
    int ly, ry;
    did_mid_reset = 0;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.paddle_ly  = 10'd0;
    bus.paddle_ry  = 10'd0;
    model_reset();
    #2;
    check_now("reset_state", model_outputs());
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk); #1;

      if (!did_mid_reset && cyc > 8000 && m_st == M_PLAY) begin
        did_mid_reset = 1;
        rst = 1'b1;
        #1;
        model_reset();
        check_now("async_reset_mid_play", model_outputs());
        q.delete();
        q.push_back(model_outputs());
        @(negedge clk); #1;
        rst = 1'b0;
      end

      if (m_st == M_IDLE)      st = ($urandom_range(0, 3) == 0);
      else if (m_st == M_OVER) st = ($urandom_range(0, 29) == 0);
      else                     st = ($urandom_range(0, 199) == 0);
      tk = ($urandom_range(0, 3) != 0);
      ly = ($urandom_range(0, 1) == 0) ? clamp_paddle(m_by + 4 - int'($urandom_range(0, 66)))
                                       : int'($urandom_range(0, 1023));
      ry = ($urandom_range(0, 1) == 0) ? clamp_paddle(m_by + 4 - int'($urandom_range(0, 66)))
                                       : int'($urandom_range(0, 1023));

      bus.start      = st;
      bus.frame_tick = tk;
      bus.paddle_ly  = 10'(ly);
      bus.paddle_ry  = 10'(ry);
      model_step(st, tk, ly, ry);
      q.push_back(model_outputs());
    end

    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    @(negedge clk); #1;

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drained got %0d pending, exp 0", q.size());

    n_checks++;
    if (did_mid_reset) n_pass++;
    else $display("FAIL mid_reset_reached got 0 exp 1");

    $display("points=%0d games=%0d", n_points, n_games);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_play_ctrl.md
# pong_play_ctrl

Game-level controller that sequences the pong ball through a game: idle, serve delay, play, point scoring and game over. Once per video frame it advances the ball position, reflects the ball off the top and bottom walls and off the two paddles, and detects misses. It keeps both scores and declares a winner. It sits between the VGA timing generator, which supplies the frame tick, and the renderer, which consumes the ball position and scores.

## Interface
Parameters:
- `H_RES`, 640: visible width, in pixels.
- `V_RES`, 480: visible height, in pixels.
- `BALL_SIZE`, 8: ball edge length, square.
- `SPEED`, 2: pixels moved per frame on each axis.
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `LEFT_PADDLE_X`, 16: left edge of the left paddle.
- `RIGHT_PADDLE_X`, 616: left edge of the right paddle.
- `SERVE_FRAMES`, 60: frame ticks the ball is held at centre before play.
- `WIN_SCORE`, 7: score that ends the game.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `start` in 1: one-cycle pulse that starts a new game.
- `paddle_ly` in 10: top row of the left paddle.
- `paddle_ry` in 10: top row of the right paddle.
- `ballx` out 10: top-left x of the ball.
- `bally` out 10: top-left y of the ball.
- `score_l` out 4: left player score.
- `score_r` out 4: right player score.
- `point_scored` out 1: one-cycle pulse when a score increments.
- `game_over` out 1: high while in GAME_OVER.

## Operation
- **States:** IDLE, SERVE, PLAY, POINT, GAME_OVER.
- **Direction bits:** `dir_x` (1 = right) and `dir_y` (1 = down).
- **Centre:** `CX = (H_RES-BALL_SIZE)/2 = 316`, `CY = (V_RES-BALL_SIZE)/2 = 236`.
- **Reset values:** state IDLE, `ballx=CX`, `bally=CY`, `dir_x=1`, `dir_y=1`, both scores 0, `point_scored=0`, `game_over=0`, serve counter 0.
- **IDLE:** ball held at centre. `start` clears the scores and the serve counter, then goes to SERVE.
- **SERVE:** ball held at centre. Each `frame_tick` increments the serve counter. The tick that makes the count equal `SERVE_FRAMES` moves the block to PLAY, with no motion on that tick.
- **PLAY:** each `frame_tick` applies one step. All compares use 11-bit unsigned arithmetic, so nothing wraps.
- **Y axis, moving down:** if `bally+SPEED >= V_RES-BALL_SIZE`, set `bally = V_RES-BALL_SIZE` and `dir_y=0`. Otherwise `bally += SPEED`.
- **Y axis, moving up:** if `bally <= SPEED`, set `bally=0` and `dir_y=1`. Otherwise `bally -= SPEED`.
- **Paddle overlap:** the ball overlaps a paddle at `py` when `bally+BALL_SIZE > py` and `bally < py+PADDLE_H`. Overlap uses the current `bally`, before the Y step.
- **Left-paddle face:** `LF = LEFT_PADDLE_X+PADDLE_W`.
- **X axis, moving left, hit:** if `LF <= ballx <= LF+SPEED` and the ball overlaps `paddle_ly`, set `ballx=LF` and `dir_x=1`.
- **X axis, moving left, miss:** else if `ballx < SPEED`, it is a miss; the right player scores.
- **X axis, moving left, otherwise:** `ballx -= SPEED`.
- **Right-paddle face:** `RF = RIGHT_PADDLE_X-BALL_SIZE`.
- **X axis, moving right, hit:** if `RF-SPEED <= ballx <= RF` and the ball overlaps `paddle_ry`, set `ballx=RF` and `dir_x=0`.
- **X axis, moving right, miss:** else if `ballx+BALL_SIZE+SPEED > H_RES`, it is a miss; the left player scores.
- **X axis, moving right, otherwise:** `ballx += SPEED`.
- **Combined steps:** the X and Y steps are independent and both apply on the same tick, so a corner reflects both axes. On a miss the position is not updated; the state goes to POINT and the scorer is latched.
- **POINT, one cycle:**
  - Increment the scorer's score and pulse `point_scored`.
  - Recentre the ball.
  - Set `dir_x` toward the player who conceded; `dir_y` is unchanged.
  - Clear the serve counter.
  - If the new score equals `WIN_SCORE`, go to GAME_OVER; otherwise go to SERVE.
- **GAME_OVER:** `game_over=1`, ball at centre, scores held. `start` clears the scores and goes to SERVE.
- **Ignored inputs:** `start` is ignored in SERVE, PLAY and POINT. `frame_tick` is ignored in IDLE, POINT and GAME_OVER.

## Timing
- All outputs are registered.
- A PLAY step is visible on `ballx`/`bally` on the cycle after `frame_tick`.
- A miss on tick cycle N gives:
  - N+1: POINT, score updated, `point_scored=1`, ball centred.
  - N+2: SERVE or GAME_OVER, with `game_over` rising at N+2.
- `start` and `frame_tick` in the same cycle in IDLE or GAME_OVER: the state goes to SERVE and the tick is not counted.
- `rst` asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

## Structure
- **Package `pong_pkg`:** the state enum `pong_state_t` and the default screen, ball and paddle constants.
- **Sub-module `ball_step`:** combinational. It takes the current position, directions and both paddle y values, and returns the next position, the next directions, and the `miss_l` and `miss_r` flags.
- **`pong_play_ctrl`:** holds the FSM, the serve counter, the score registers and the output registers.

## Test plan
1. **Reset mid-play:** assert `rst` during PLAY with `ballx=100` → immediately `ballx=316`, `bally=236`, IDLE, scores 0, `game_over=0`.
2. **Serve delay:** `start`, then 60 ticks → ball stays at (316,236). Tick 61 → (318,238).
3. **Bottom wall:** PLAY, `bally=471`, `dir_y=1`, tick → `bally=472` and `dir_y=0`. Next tick → `bally=470`.
4. **Left paddle hit:** `ballx=25`, moving left, `bally=220`, `paddle_ly=200`, tick → `ballx=24`. Next tick → `ballx=26`.
5. **Left miss:** `ballx=1`, moving left, `bally=300`, `paddle_ly=0`, tick → next cycle `score_r` goes 0→1, `point_scored` is high for exactly 1 cycle, ball at (316,236), `dir_x=0`. The cycle after, SERVE.
6. **Win then restart:** `score_l=6`, right miss → `score_l=7`, then GAME_OVER with `game_over=1`. Further ticks cause no movement. `start` → scores 0 and SERVE.
